// File: rtl/mips_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes,
// opcode/funct constants, datapath select encodings, instruction classes
// and the packed control word that forms the external `signals` bus.
package mips_mc_ctrl_pkg;

    // State codes S1..S12; 0, 13, 14 and 15 are unused and recover to S1.
    localparam logic [3:0] S1  = 4'd1;
    localparam logic [3:0] S2  = 4'd2;
    localparam logic [3:0] S3  = 4'd3;
    localparam logic [3:0] S4  = 4'd4;
    localparam logic [3:0] S5  = 4'd5;
    localparam logic [3:0] S6  = 4'd6;
    localparam logic [3:0] S7  = 4'd7;
    localparam logic [3:0] S8  = 4'd8;
    localparam logic [3:0] S9  = 4'd9;
    localparam logic [3:0] S10 = 4'd10;
    localparam logic [3:0] S11 = 4'd11;
    localparam logic [3:0] S12 = 4'd12;

    // Primary opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0]).
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;

    // Next-PC select.
    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JUMP = 2'd2;
    localparam logic [1:0] NPC_JR   = 2'd3;

    // GPR write data select.
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    // GPR write address select.
    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    // Immediate extension mode.
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    // ALU function.
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;

    // Instruction class produced by the op/funct decoder.
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_ADDU    = 4'd1,
        CLS_SUBU    = 4'd2,
        CLS_JR      = 4'd3,
        CLS_LW      = 4'd4,
        CLS_SW      = 4'd5,
        CLS_BEQ     = 4'd6,
        CLS_J       = 4'd7,
        CLS_JAL     = 4'd8,
        CLS_ORI     = 4'd9,
        CLS_LUI     = 4'd10
    } instr_cls_e;

    // Control word; field order is the bit order of the `signals` bus.
    typedef struct packed {
        logic       pcWr;
        logic [1:0] npcOp;
        logic       irWr;
        logic       regWr;
        logic [1:0] regDst;
        logic [1:0] wdSel;
        logic [1:0] extOp;
        logic       aluSrc;
        logic [1:0] aluOp;
        logic       dmWr;
        logic       illegal;
    } ctrl_sig_t;

    // First state after decode for each instruction class.
    function automatic logic [3:0] decodeNextState(input instr_cls_e cls);
        logic [3:0] nxt;
        case (cls)
            CLS_LW, CLS_SW:          nxt = S3;
            CLS_ADDU, CLS_SUBU:      nxt = S7;
            CLS_JR, CLS_J, CLS_JAL:  nxt = S10;
            CLS_BEQ:                 nxt = S9;
            CLS_ORI, CLS_LUI:        nxt = S11;
            default:                 nxt = S1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_dec.sv
// Combinational op/funct decoder: maps the instruction held in the IR onto
// one of the supported instruction classes, or CLS_ILLEGAL.
module mips_mc_ctrl_dec
    import mips_mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output instr_cls_e cls
);

    // Classify the opcode; R-type needs funct to tell addu/subu/jr apart.
    always_comb begin
        cls = CLS_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADDU: cls = CLS_ADDU;
                    FUNCT_SUBU: cls = CLS_SUBU;
                    FUNCT_JR:   cls = CLS_JR;
                    default:    cls = CLS_ILLEGAL;
                endcase
            end
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            OP_ORI:  cls = CLS_ORI;
            OP_LUI:  cls = CLS_LUI;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle main controller for the mips core. Holds the state register
// and decodes all datapath write enables and selects from the current state
// and the instruction class of the IR contents.
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter int STATUS_W = 4,
    parameter int SIG_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    output logic [STATUS_W-1:0] status,
    output logic                PCWr,
    output logic [1:0]          NPCOp,
    output logic                IRWr,
    output logic                RegWr,
    output logic [1:0]          RegDst,
    output logic [1:0]          WDSel,
    output logic [1:0]          ExtOp,
    output logic                ALUSrc,
    output logic [1:0]          ALUOp,
    output logic                DMWr,
    output logic                illegal,
    output logic [SIG_W-1:0]    signals
);

    logic [STATUS_W-1:0] state_q;
    logic [STATUS_W-1:0] state_d;
    instr_cls_e          cls;
    ctrl_sig_t           ctrl;
    ctrl_sig_t           ctrlOut;

    mips_mc_ctrl_dec u_dec (
        .op    (op),
        .funct (funct),
        .cls   (cls)
    );

    // Next-state selection and per-state control word.
    always_comb begin
        ctrl    = '0;
        state_d = S1;
        case (state_q)
            S1: begin
                ctrl.pcWr  = 1'b1;
                ctrl.irWr  = 1'b1;
                ctrl.npcOp = NPC_PC4;
                state_d    = S2;
            end
            S2: begin
                ctrl.illegal = (cls == CLS_ILLEGAL);
                state_d      = decodeNextState(cls);
            end
            S3: begin
                ctrl.aluSrc = 1'b1;
                ctrl.extOp  = EXT_SIGN;
                ctrl.aluOp  = ALU_ADD;
                if (cls == CLS_LW) begin
                    state_d = S4;
                end else if (cls == CLS_SW) begin
                    state_d = S6;
                end else begin
                    state_d = S1;
                end
            end
            S4: begin
                state_d = S5;
            end
            S5: begin
                ctrl.regWr  = 1'b1;
                ctrl.regDst = RD_RT;
                ctrl.wdSel  = WD_DM;
                state_d     = S1;
            end
            S6: begin
                ctrl.dmWr = 1'b1;
                state_d   = S1;
            end
            S7: begin
                ctrl.aluOp = (cls == CLS_SUBU) ? ALU_SUB : ALU_ADD;
                state_d    = S8;
            end
            S8: begin
                ctrl.regWr  = 1'b1;
                ctrl.regDst = RD_RD;
                ctrl.wdSel  = WD_ALU;
                state_d     = S1;
            end
            S9: begin
                ctrl.aluOp = ALU_SUB;
                ctrl.npcOp = NPC_BR;
                ctrl.pcWr  = zero;
                state_d    = S1;
            end
            S10: begin
                ctrl.pcWr  = 1'b1;
                ctrl.npcOp = (cls == CLS_JR) ? NPC_JR : NPC_JUMP;
                if (cls == CLS_JAL) begin
                    ctrl.regWr  = 1'b1;
                    ctrl.regDst = RD_RA;
                    ctrl.wdSel  = WD_PC4;
                end
                state_d = S1;
            end
            S11: begin
                ctrl.aluSrc = 1'b1;
                ctrl.aluOp  = ALU_OR;
                ctrl.extOp  = (cls == CLS_LUI) ? EXT_LUI : EXT_ZERO;
                state_d     = S12;
            end
            S12: begin
                ctrl.regWr  = 1'b1;
                ctrl.regDst = RD_RT;
                ctrl.wdSel  = WD_ALU;
                state_d     = S1;
            end
            default: begin
                state_d = S1;
            end
        endcase
    end

    // State register; reset returns to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S1;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset squashes every enable and select so no partial write escapes.
    always_comb begin
        ctrlOut = ctrl;
        if (rst) begin
            ctrlOut = '0;
        end
    end

    assign status  = state_q;
    assign PCWr    = ctrlOut.pcWr;
    assign NPCOp   = ctrlOut.npcOp;
    assign IRWr    = ctrlOut.irWr;
    assign RegWr   = ctrlOut.regWr;
    assign RegDst  = ctrlOut.regDst;
    assign WDSel   = ctrlOut.wdSel;
    assign ExtOp   = ctrlOut.extOp;
    assign ALUSrc  = ctrlOut.aluSrc;
    assign ALUOp   = ctrlOut.aluOp;
    assign DMWr    = ctrlOut.dmWr;
    assign illegal = ctrlOut.illegal;
    assign signals = ctrlOut;

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle main controller for the `mips` core.
- Sits between the IR/decode path and the datapath (IFU, GPR, ALU, DM, NPC).
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives all write enables and mux selects.
- Exposes `status` and a packed `signals` bus so system benches can step the core per instruction by waiting for `S1`.

Parameters:
- `STATUS_W`, 4, width of state encoding; state codes `S1`..`S12` are defined in the macro header.
- `SIG_W`, 16, width of the packed `signals` bus.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `op`  in  6  IR[31:26], valid from `S2` onward.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU equal flag, valid in the branch state.
- `status`  out  STATUS_W  current state.
- `PCWr`  out  1  PC write enable.
- `NPCOp`  out  2  next-PC select: 0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr.
- `IRWr`  out  1  IR write enable.
- `RegWr`  out  1  GPR write enable.
- `RegDst`  out  2  write address select: 0 = rt, 1 = rd, 2 = $31.
- `WDSel`  out  2  write data select: 0 = ALU, 1 = DM, 2 = PC+4.
- `ExtOp`  out  2  immediate extension: 0 = zero, 1 = sign, 2 = lui (<<16).
- `ALUSrc`  out  1  ALU B operand: 0 = reg, 1 = imm.
- `ALUOp`  out  2  ALU function: 0 = add, 1 = sub, 2 = or.
- `DMWr`  out  1  data memory write enable.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.
- `signals`  out  SIG_W  concatenation `{PCWr,NPCOp,IRWr,RegWr,RegDst,WDSel,ExtOp,ALUSrc,ALUOp,DMWr,illegal}`.

Behaviour:
- Reset:
  - On a `clk` edge with `rst` = 1, `status` becomes `S1`.
  - All write enables (`PCWr`, `IRWr`, `RegWr`, `DMWr`) and `illegal` are forced to 0 while `rst` is high.
  - All selects are 0 while `rst` is high.
- Moore outputs:
  - Outputs decode combinationally from `status`, plus `op`/`funct` latched in the IR.
  - `PCWr` in the branch state additionally depends on `zero`.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr.
- States and transitions:
  - `S1` Fetch: `IRWr`=1, `PCWr`=1, `NPCOp`=0. Next: `S2`.
  - `S2` Decode/register read. Next by opcode:
    - lw/sw → `S3`
    - R-type addu/subu → `S7`
    - jr → `S10`
    - beq → `S9`
    - j/jal → `S10`
    - ori/lui → `S11`
    - otherwise → `S1` with `illegal`=1.
  - `S3` Address calc: `ALUSrc`=1, `ExtOp`=1, `ALUOp`=0. Next: `S4` for lw, `S6` for sw.
  - `S4` Memory read. Next: `S5`.
  - `S5` Load writeback: `RegWr`=1, `RegDst`=0, `WDSel`=1. Next: `S1`.
  - `S6` Store: `DMWr`=1. Next: `S1`.
  - `S7` R-type execute: `ALUOp`=0 for addu, 1 for subu. Next: `S8`.
  - `S8` R-type writeback: `RegWr`=1, `RegDst`=1, `WDSel`=0. Next: `S1`.
  - `S9` Branch: `ALUOp`=1, `NPCOp`=1, `PCWr`=`zero`. Next: `S1`.
  - `S10` Jump:
    - `PCWr`=1.
    - `NPCOp`=2 for j/jal, 3 for jr.
    - jal also sets `RegWr`=1, `RegDst`=2, `WDSel`=2; PC+4 is captured before `PCWr` takes effect.
    - Next: `S1`.
  - `S11` I-type execute:
    - `ALUSrc`=1, `ALUOp`=2.
    - `ExtOp`=0 for ori; for lui, `ExtOp`=2 with `ALUOp`=2 against $0.
    - Next: `S12`.
  - `S12` I-type writeback: `RegWr`=1, `RegDst`=0, `WDSel`=0. Next: `S1`.
  - Any undefined `status` code → `S1` on the next edge.
- Cycle counts (including fetch):
  - 5: lw
  - 4: addu, subu, ori, lui, sw
  - 3: beq, j, jal, jr
  - 2: illegal
- Exclusivity:
  - At most one of `RegWr`/`DMWr` is high in any cycle.
  - `IRWr` is high only in `S1`.
- Reset mid-instruction: any partial write is suppressed on the reset edge and the next state is `S1`; no write enable is high in the cycle after reset deasserts until the `S1` actions.

Decomposition:
- Shared macro header (existing `macro.v`): `S1`..`S12` codes, opcode/funct constants, `NPCOp`/`WDSel`/`RegDst`/`ExtOp`/`ALUOp` encodings.
- One natural sub-module, `mips_mc_ctrl_dec`: a combinational op/funct → instruction-class decoder used by the next-state logic.
- State register and output decode stay in `mips_mc_ctrl`.

Test Plan:
- Reset then addu (op=0, funct=0x21) → `status` sequence S1, S2, S7, S8, S1; `RegWr`=1 and `RegDst`=1 only in `S8`.
- lw (op=0x23) → S1, S2, S3, S4, S5, S1; `WDSel`=1 and `RegWr`=1 in `S5`; `DMWr` never high.
- beq (op=0x04):
  - with `zero`=1 → `PCWr`=1, `NPCOp`=1 in `S9`.
  - repeat with `zero`=0 → `PCWr`=0 in `S9`; both runs return to `S1`.
- jal (op=0x03) → S1, S2, S10; in `S10`: `PCWr`=1, `NPCOp`=2, `RegWr`=1, `RegDst`=2, `WDSel`=2.
- Illegal op=0x3F → `illegal` pulses for exactly 1 cycle in `S2`, next state `S1`, no write enable asserted.
- sw issued, `rst` asserted during `S3` → `status`=`S1` on the next edge, `DMWr` never high; after release, fetch proceeds normally.
